// File: rtl/fdiv_share_arb_if.sv
// Bundle of requester-side and divider-side signals for fdiv_share_arb.
// slave = the arbiter; master = the requesters plus the divider instance.
interface fdiv_share_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] dividend_in;
  logic [NREQ*32-1:0] divisor_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_quotient;
  logic [31:0]        resp_rem;
  logic               resp_err;
  logic               arb_busy;
  logic [31:0]        div_dividend;
  logic [31:0]        div_divisor;
  logic               div_start;
  logic               div_busy;
  logic               div_ready;
  logic [31:0]        div_quotient;
  logic [31:0]        div_rem;

  modport slave (
    input  req, dividend_in, divisor_in, div_busy, div_ready, div_quotient, div_rem,
    output gnt, resp_valid, resp_quotient, resp_rem, resp_err, arb_busy,
           div_dividend, div_divisor, div_start
  );

  modport master (
    output req, dividend_in, divisor_in, div_busy, div_ready, div_quotient, div_rem,
    input  gnt, resp_valid, resp_quotient, resp_rem, resp_err, arb_busy,
           div_dividend, div_divisor, div_start
  );
endinterface

// File: rtl/fdiv_share_arb.sv
// Round-robin arbiter/sequencer sharing one divider among NREQ requesters.
// Optional macro FDIV_ZERO_BYPASS_EN answers zero-divisor requests locally.
module fdiv_share_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              clrn,
  fdiv_share_arb_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic [31:0]     quot_q, quot_d;
  logic [31:0]     rem_q, rem_d;
  logic            err_q, err_d;
  logic [31:0]     dvd_q, dvd_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            start_q, start_d;
`ifdef FDIV_ZERO_BYPASS_EN
  logic            byp_q, byp_d;
`endif

  logic            found;
  logic [IW-1:0]   win;
  logic [31:0]     win_dvd, win_dvs;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[wrap_idx(ptr_q, k)]) begin
        found = 1'b1;
        win   = wrap_idx(ptr_q, k);
      end
    end
  end

  assign win_dvd = bus.dividend_in[{win, 5'b00000} +: 32];
  assign win_dvs = bus.divisor_in[{win, 5'b00000} +: 32];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
`ifdef FDIV_ZERO_BYPASS_EN
    byp_d   = byp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d      = win;
          dvd_d      = win_dvd;
          dvs_d      = win_dvs;
          gnt_d[win] = 1'b1;
`ifdef FDIV_ZERO_BYPASS_EN
          byp_d      = (win_dvs[30:0] == 31'd0);
          start_d    = (win_dvs[30:0] != 31'd0);
`else
          start_d    = 1'b1;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
`ifdef FDIV_ZERO_BYPASS_EN
        if (byp_q) begin
          quot_d      = (dvd_q[30:0] == 31'd0) ? 32'h7FC00000
                                                : {dvd_q[31] ^ dvs_q[31], 31'h7F800000};
          rem_d       = '0;
          err_d       = 1'b0;
          rv_d[ptr_q] = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      WAIT: begin
        if (bus.div_ready && !bus.div_busy) begin
          quot_d      = bus.div_quotient;
          rem_d       = bus.div_rem;
          err_d       = 1'b0;
          rv_d[ptr_q] = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quot_d      = 32'h7FC00000;
          rem_d       = '0;
          err_d       = 1'b1;
          rv_d[ptr_q] = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      start_q <= 1'b0;
`ifdef FDIV_ZERO_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      start_q <= start_d;
`ifdef FDIV_ZERO_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.resp_valid    = rv_q;
  assign bus.resp_quotient = quot_q;
  assign bus.resp_rem      = rem_q;
  assign bus.resp_err      = err_q;
  assign bus.arb_busy      = (state_q != IDLE);
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign bus.div_start     = start_q;
endmodule

// File: tb/tb_fdiv_share_arb.sv
// Directed bench for fdiv_share_arb with a small latency-programmable divider model.
module tb_fdiv_share_arb;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] QK = 32'h5A5A0000;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  fdiv_share_arb_if #(.NREQ(NREQ)) bus ();

  fdiv_share_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int extra_gnt = 0;
  int starts    = 0;
  int lat       = 5;
  bit never_ready = 1'b0;
  int mcnt;
  logic [31:0] pend_q;

  function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40600000 && b == 32'h40000000) return 32'h3FE00000;
    return a ^ b ^ QK;
  endfunction

  // Divider model: busy for lat cycles after start, then ready held until next start.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.div_busy     <= 1'b0;
      bus.div_ready    <= 1'b0;
      bus.div_quotient <= '0;
      bus.div_rem      <= '0;
      mcnt             <= 0;
    end else if (bus.div_start) begin
      bus.div_busy  <= 1'b1;
      bus.div_ready <= 1'b0;
      mcnt          <= lat - 1;
      pend_q        <= model_q(bus.div_dividend, bus.div_divisor);
    end else if (bus.div_busy && !never_ready) begin
      if (mcnt == 0) begin
        bus.div_busy     <= 1'b0;
        bus.div_ready    <= 1'b1;
        bus.div_quotient <= pend_q;
        bus.div_rem      <= pend_q ^ 32'h0000FFFF;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  always @(posedge clk) if (bus.div_start) starts <= starts + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.dividend_in[32*i +: 32] = a;
    bus.divisor_in[32*i +: 32]  = b;
  endtask

  task automatic wait_gnt(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (bus.gnt == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("gnt_seen", 32'(|bus.gnt), 32'd1);
    for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) idx = i;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0) extra_gnt++;
    end while (bus.resp_valid == '0 && cyc < 200);
    check_eq("resp_seen", 32'(|bus.resp_valid), 32'd1);
    $display("op resp_valid=%b q=%h rem=%h err=%0d lat=%0d",
             bus.resp_valid, bus.resp_quotient, bus.resp_rem, bus.resp_err, cyc);
  endtask

  initial begin
    int idx, cyc, s0, rv_seen;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [31:0] d, v;

    bus.req = '0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_gnt",   32'(bus.gnt), 32'd0);
    check_eq("rst_rv",    32'(bus.resp_valid), 32'd0);
    check_eq("rst_busy",  32'(bus.arb_busy), 32'd0);
    check_eq("rst_start", 32'(bus.div_start), 32'd0);
    check_eq("rst_quot",  bus.resp_quotient, 32'd0);
    check_eq("rst_dvd",   bus.div_dividend, 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Single op: 3.5 / 2.0
    set_op(0, 32'h40600000, 32'h40000000);
    bus.req = 4'b0001;
    wait_gnt(idx, cyc);
    check_eq("t1_gnt_lat", 32'(cyc), 32'd1);
    check_eq("t1_gnt", 32'(bus.gnt), 32'b0001);
    check_eq("t1_start", 32'(bus.div_start), 32'd1);
    check_eq("t1_dvd", bus.div_dividend, 32'h40600000);
    check_eq("t1_dvs", bus.div_divisor, 32'h40000000);
    bus.req = '0;
    wait_resp(cyc);
    check_eq("t1_rv", 32'(bus.resp_valid), 32'b0001);
    check_eq("t1_quot", bus.resp_quotient, 32'h3FE00000);
    check_eq("t1_err", 32'(bus.resp_err), 32'd0);
    check_eq("t1_starts", 32'(starts), 32'd1);
    @(negedge clk);
    check_eq("t1_rv_clr", 32'(bus.resp_valid), 32'd0);
    check_eq("t1_quot_hold", bus.resp_quotient, 32'h3FE00000);
    check_eq("t1_idle", 32'(bus.arb_busy), 32'd0);

    // Reset so the round-robin sequence starts at requester 0
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // Round robin with all requests held
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000 + (i << 20), 32'h40000000 + i);
    bus.req = 4'b1111;
    extra_gnt = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(idx, cyc);
      check_eq("rr_idx", 32'(idx), 32'(order[k]));
      check_eq("rr_onehot", 32'(bus.gnt), 32'd1 << order[k]);
      check_eq("rr_dvd", bus.div_dividend, 32'h3F800000 + (order[k] << 20));
      if (k == 4) bus.req = '0;
      wait_resp(cyc);
      check_eq("rr_rv", 32'(bus.resp_valid), 32'd1 << order[k]);
      check_eq("rr_quot", bus.resp_quotient,
               model_q(32'h3F800000 + (order[k] << 20), 32'h40000000 + order[k]));
      check_eq("rr_rem", bus.resp_rem,
               model_q(32'h3F800000 + (order[k] << 20), 32'h40000000 + order[k]) ^ 32'h0000FFFF);
    end
    check_eq("rr_no_gnt_busy", 32'(extra_gnt), 32'd0);

    // Stale ready: model ready still high from the previous op during ISSUE
    lat = 3;
    set_op(2, 32'h41200000, 32'h40400000);
    bus.req = 4'b0100;
    wait_gnt(idx, cyc);
    bus.req = '0;
    wait_resp(cyc);
    check_eq("stale_lat", 32'(cyc), 32'd5);
    check_eq("stale_quot", bus.resp_quotient, 32'h41200000 ^ 32'h40400000 ^ QK);

    // Timeout: divider never becomes ready
    never_ready = 1'b1;
    bus.req = 4'b0010;
    wait_gnt(idx, cyc);
    bus.req = '0;
    wait_resp(cyc);
    check_eq("to_lat", 32'(cyc), 32'(TIMEOUT + 1));
    check_eq("to_rv", 32'(bus.resp_valid), 32'b0010);
    check_eq("to_quot", bus.resp_quotient, 32'h7FC00000);
    check_eq("to_rem", bus.resp_rem, 32'd0);
    check_eq("to_err", 32'(bus.resp_err), 32'd1);
    @(negedge clk);
    check_eq("to_idle", 32'(bus.arb_busy), 32'd0);
    check_eq("to_err_hold", 32'(bus.resp_err), 32'd1);
    never_ready = 1'b0;

    // Reset in WAIT drops the operation
    lat = 5;
    bus.req = 4'b1000;
    wait_gnt(idx, cyc);
    bus.req = '0;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(bus.arb_busy), 32'd0);
    check_eq("mid_rst_err", 32'(bus.resp_err), 32'd0);
    check_eq("mid_rst_quot", bus.resp_quotient, 32'd0);
    check_eq("mid_rst_dvd", bus.div_dividend, 32'd0);
    rv_seen = 0;
    repeat (2) begin @(negedge clk); if (bus.resp_valid != '0) rv_seen++; end
    clrn = 1'b1;
    repeat (10) begin @(negedge clk); if (bus.resp_valid != '0) rv_seen++; end
    check_eq("mid_rst_no_rv", 32'(rv_seen), 32'd0);
    bus.req = 4'b1111;
    wait_gnt(idx, cyc);
    check_eq("post_rst_first", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    wait_resp(cyc);
    @(negedge clk);

    // Zero divisor handling
    d = 32'h40A00000;
    v = 32'h80000000;
    set_op(1, d, v);
    s0 = starts;
    bus.req = 4'b0010;
    wait_gnt(idx, cyc);
    bus.req = '0;
`ifdef FDIV_ZERO_BYPASS_EN
    check_eq("byp_start", 32'(bus.div_start), 32'd0);
    wait_resp(cyc);
    check_eq("byp_lat", 32'(cyc), 32'd1);
    check_eq("byp_quot", bus.resp_quotient, 32'hFF800000);
    check_eq("byp_rem", bus.resp_rem, 32'd0);
    check_eq("byp_err", 32'(bus.resp_err), 32'd0);
    check_eq("byp_starts", 32'(starts - s0), 32'd0);
    @(negedge clk);
    set_op(1, 32'h0, 32'h0);
    bus.req = 4'b0010;
    wait_gnt(idx, cyc);
    bus.req = '0;
    wait_resp(cyc);
    check_eq("byp_nan", bus.resp_quotient, 32'h7FC00000);
    check_eq("byp_nan_starts", 32'(starts - s0), 32'd0);
`else
    check_eq("zdiv_start", 32'(bus.div_start), 32'd1);
    wait_resp(cyc);
    check_eq("zdiv_quot", bus.resp_quotient, d ^ v ^ QK);
    check_eq("zdiv_starts", 32'(starts - s0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fdiv_share_arb.md
Name: fdiv_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one Goldschmidt single-precision divider among NREQ requesters.
- Captures one requester's operands, pulses the divider start, and waits for divider ready/not-busy, with a timeout.
- Returns quotient and remainder to the granted requester with a one-cycle valid pulse.
- Sits between FPU issue ports and the divider instance; only one division is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before an error response (>=2).

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester; held high with operands stable until gnt seen
- dividend_in  in  NREQ*32  requester i operand at bits [32i+31:32i]
- divisor_in  in  NREQ*32  same packing
- gnt  out  NREQ  one-cycle acceptance pulse, one-hot
- resp_valid  out  NREQ  one-cycle result pulse, one-hot
- resp_quotient  out  32  result, valid with resp_valid
- resp_rem  out  32  remainder, valid with resp_valid
- resp_err  out  1  timeout flag, valid with resp_valid
- arb_busy  out  1  high whenever state != IDLE
- div_dividend  out  32  registered operand to divider
- div_divisor  out  32  registered operand to divider
- div_start  out  1  one-cycle start pulse to divider
- div_busy  in  1  divider busy
- div_ready  in  1  divider result ready
- div_quotient  in  32  divider quotient
- div_rem  in  32  divider remainder

Behaviour:
- Reset (clrn=0, async): state=IDLE; gnt, resp_valid, div_start, resp_err, arb_busy = 0; resp_quotient, resp_rem, div_dividend, div_divisor = 0; timeout counter = 0; rr pointer = NREQ-1, so req[0] wins first.
- Reset mid-operation: the in-flight result is dropped and no resp_valid is issued. The divider shares clrn.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, edge with any req bit set:
  - Winner = first set bit searching from ptr+1 upward, wrapping.
  - ptr <= winner.
  - div_dividend/div_divisor <= winner's operands.
  - gnt[winner] <= 1 and div_start <= 1.
  - -> ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle; gnt and div_start visible): -> WAIT, clearing gnt and div_start and counter.
- WAIT, each edge:
  - If div_ready=1 and div_busy=0: resp_quotient <= div_quotient, resp_rem <= div_rem, resp_err <= 0, resp_valid[id] <= 1; -> RESP.
  - Else if counter = TIMEOUT-1: resp_quotient <= 32'h7FC00000, resp_rem <= 0, resp_err <= 1, resp_valid[id] <= 1; -> RESP.
  - Else counter++.
  - Ready is ignored in the ISSUE cycle, so a stale ready from a prior op is never taken.
- RESP (1 cycle; resp_valid visible): -> IDLE and clear resp_valid. resp_quotient, resp_rem and resp_err hold until the next response.
- Minimum turnaround: IDLE -> ISSUE -> WAIT(>=1) -> RESP -> IDLE, i.e. 4 cycles per op with no back-to-back overlap.
- Requests arriving while arb_busy=1 wait; req changes outside IDLE sampling are ignored.
- Dropping req before gnt withdraws the request, with no side effects.
- A requester may reassert req in the same cycle as its resp_valid. Round-robin still gives other pending requesters priority.
- Unpack operands with an indexed part-select. No arithmetic is done on the data.

Optional Feature:
- Macro FDIV_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's divisor[30:0]==0, gnt pulses as normal but div_start stays 0, and the FSM goes ISSUE -> RESP directly:
  - Quotient = 32'h7FC00000 if dividend[30:0]==0.
  - Otherwise {dividend[31]^divisor[31], 31'h7F800000}.
  - resp_rem=0, resp_err=0.
  - Latency from gnt to resp_valid is 1 cycle.
- Not defined: zero divisors go to the divider like any other operand.

Test Plan:
- Reset, then req=4'b0001 with 3.5 (0x40600000) / 2.0 (0x40000000); divider model ready after 5 cycles with 0x3FE00000 -> gnt[0] 1 cycle after req, div_start one pulse, resp_valid[0] with quotient 0x3FE00000, resp_err=0.
- req=4'b1111 held, each requester re-requesting after its response -> grant order 0,1,2,3,0; no gnt while arb_busy; each gnt one-hot.
- Divider model never asserts ready, TIMEOUT=64 -> resp_valid[id] exactly 64 WAIT cycles after ISSUE, quotient 0x7FC00000, resp_err=1, then IDLE.
- Stale div_ready=1 held high during ISSUE, deasserted one cycle later, true ready 3 cycles later -> result captured only on the true ready.
- clrn pulsed low during WAIT -> all outputs 0 immediately, no resp_valid; next request is granted to req[0] first.
- With FDIV_ZERO_BYPASS_EN, 5.0 / -0.0 (0x80000000) -> div_start never asserted, resp quotient 0xFF800000 one cycle after gnt; 0/0 -> 0x7FC00000.
